// File: rtl/riscv_dmem_resp_pkg.sv
// Shared constants and types for the data-memory responder: MMIO map,
// status bit positions and the address-region decode type.
package riscv_dmem_resp_pkg;

   localparam int DW = 32;

   localparam logic [DW-1:0] MMIO_BASE = 32'h1000_0000;
   localparam logic [DW-1:0] GPIO_OFS  = 32'h0000_0000;
   localparam logic [DW-1:0] CNT_OFS   = 32'h0000_0004;
   localparam logic [DW-1:0] CMP_OFS   = 32'h0000_0008;
   localparam logic [DW-1:0] STAT_OFS  = 32'h0000_000C;

   localparam int STAT_IRQ_BIT = 0;
   localparam int STAT_ERR_BIT = 1;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_RAM,
      REG_GPIO,
      REG_CNT,
      REG_CMP,
      REG_STAT
   } region_e;

endpackage

// File: rtl/riscv_dmem_resp_timer.sv
// Free-running 32-bit timer with a compare register and a sticky
// interrupt-pending flag. Stores to COUNT override the increment; the match
// uses the pre-edge COUNT and CMP values, and a match beats a clear.
module riscv_dmem_resp_timer
   import riscv_dmem_resp_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cnt_we_i,
   input  logic          cmp_we_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          irq_clr_i,
   output logic [DW-1:0] count_o,
   output logic [DW-1:0] cmp_o,
   output logic          irq_o
);

   logic [DW-1:0] count_q, count_d;
   logic [DW-1:0] cmp_q, cmp_d;
   logic          irq_q, irq_d;

   // Next-state: store beats increment, match beats clear.
   always_comb begin
      count_d = cnt_we_i ? wdata_i : count_q + 32'd1;
      cmp_d   = cmp_we_i ? wdata_i : cmp_q;
      irq_d   = irq_q;
      if (irq_clr_i)
         irq_d = 1'b0;
      if (count_q == cmp_q)
         irq_d = 1'b1;
   end

   // Timer state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         cmp_q   <= 32'hFFFF_FFFF;
         irq_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         irq_q   <= irq_d;
      end
   end

   assign count_o = count_q;
   assign cmp_o   = cmp_q;
   assign irq_o   = irq_q;

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the core's MEM stage: word RAM with
// combinational read, small MMIO window (GPIO, timer, status) and a sticky
// access-error flag that holds the address of the first bad access.
module riscv_dmem_resp
   import riscv_dmem_resp_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [DW-1:0] data_addr_i,
   input  logic [DW-1:0] data_data_i,
   output logic [DW-1:0] data_data_o,
   input  logic          data_Rd_en_i,
   input  logic          data_Wr_en_i,
   output logic [7:0]    gpio_o,
   output logic          timer_irq_o,
   output logic          err_o,
   output logic [DW-1:0] err_addr_o
);

   logic [DW-1:0] ram_q [DEPTH];
   logic [AW-1:0] ram_idx;

   region_e       region;
   logic          acc_err;
   logic          legal_rd, legal_wr;
   logic          ram_we, gpio_we, cnt_we, cmp_we, irq_clr, err_clr;

   logic [7:0]    gpio_q, gpio_d;
   logic          err_q, err_d;
   logic [DW-1:0] err_addr_q, err_addr_d;

   logic [DW-1:0] count, cmp;
   logic          irq;
   logic [DW-1:0] status;

   assign ram_idx = data_addr_i[AW+1:2];

   // Address decode into RAM / one MMIO register / nothing.
   always_comb begin
      region = REG_NONE;
      if (data_addr_i[DW-1:AW+2] == '0)
         region = REG_RAM;
      else if (data_addr_i[DW-1:2] == MMIO_BASE[DW-1:2] + GPIO_OFS[DW-1:2])
         region = REG_GPIO;
      else if (data_addr_i[DW-1:2] == MMIO_BASE[DW-1:2] + CNT_OFS[DW-1:2])
         region = REG_CNT;
      else if (data_addr_i[DW-1:2] == MMIO_BASE[DW-1:2] + CMP_OFS[DW-1:2])
         region = REG_CMP;
      else if (data_addr_i[DW-1:2] == MMIO_BASE[DW-1:2] + STAT_OFS[DW-1:2])
         region = REG_STAT;
   end

   // Access qualification; an erroring access is fully suppressed.
   always_comb begin
      acc_err  = (data_Rd_en_i | data_Wr_en_i) &
                 ((data_addr_i[1:0] != 2'b00) | (region == REG_NONE) |
                  (data_Rd_en_i & data_Wr_en_i));
      legal_rd = data_Rd_en_i & ~acc_err;
      legal_wr = data_Wr_en_i & ~acc_err;
      // Reset drops any in-flight store, including the RAM which has no reset.
      ram_we   = legal_wr & ~rst_i & (region == REG_RAM);
      gpio_we  = legal_wr & (region == REG_GPIO);
      cnt_we   = legal_wr & (region == REG_CNT);
      cmp_we   = legal_wr & (region == REG_CMP);
      irq_clr  = legal_wr & (region == REG_STAT) & data_data_i[STAT_IRQ_BIT];
      err_clr  = legal_wr & (region == REG_STAT) & data_data_i[STAT_ERR_BIT];
   end

   // Status word as seen by software.
   always_comb begin
      status               = '0;
      status[STAT_IRQ_BIT] = irq;
      status[STAT_ERR_BIT] = err_q;
   end

   // Zero-latency read mux; the core samples it at the edge ending MEM.
   always_comb begin
      data_data_o = '0;
      if (!rst_i && legal_rd) begin
         case (region)
            REG_RAM:  data_data_o = ram_q[ram_idx];
            REG_GPIO: data_data_o = {24'b0, gpio_q};
            REG_CNT:  data_data_o = count;
            REG_CMP:  data_data_o = cmp;
            REG_STAT: data_data_o = status;
            default:  data_data_o = '0;
         endcase
      end
   end

   // Next-state for GPIO and the sticky error; a new error beats a clear.
   always_comb begin
      gpio_d     = gpio_we ? data_data_i[7:0] : gpio_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (err_clr)
         err_d = 1'b0;
      if (acc_err) begin
         err_d = 1'b1;
         if (!err_q || err_clr)
            err_addr_d = data_addr_i;
      end
   end

   // Control registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gpio_q     <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         gpio_q     <= gpio_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // RAM write port; contents are intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (ram_we)
         ram_q[ram_idx] <= data_data_i;
   end

   riscv_dmem_resp_timer u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cnt_we_i  (cnt_we),
      .cmp_we_i  (cmp_we),
      .wdata_i   (data_data_i),
      .irq_clr_i (irq_clr),
      .count_o   (count),
      .cmp_o     (cmp),
      .irq_o     (irq)
   );

   assign gpio_o      = gpio_q;
   assign timer_irq_o = irq;
   assign err_o       = err_q;
   assign err_addr_o  = err_addr_q;

endmodule
